// File: rtl/std_shared_fu_pkg.sv
// Shared types and constants for the shared functional-unit scheduler.
package std_shared_fu_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/std_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at last_grant+1 and wraps.
module std_rr_arbiter
    import std_shared_fu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_grant,
    output logic            valid,
    output logic [ID_W-1:0] grant
);

    logic [ID_W-1:0] idx;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = '0;
        // Walk from farthest to nearest so the nearest requester is the last write and wins.
        for (int i = NREQ; i >= 1; i--) begin
            idx = ID_W'((int'(last_grant) + i) % NREQ);
            if (req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/std_shared_fu_sched.sv
// Round-robin scheduler sharing one add/sub/mul unit among NREQ go/done requesters.
// Define SHARED_FU_DIV_EN to add an unsigned divider for op 11; otherwise op 11 yields 0.
module std_shared_fu_sched
    import std_shared_fu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_go,
    input  logic [OP_W*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0]    req_left,
    input  logic [WIDTH*NREQ-1:0]    req_right,
    output logic [NREQ-1:0]          req_done,
    output logic [WIDTH-1:0]         out,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    sched_state_t     state;
    fu_op_t           op_q;
    logic [WIDTH-1:0] left_q;
    logic [WIDTH-1:0] right_q;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  last_grant;
    logic             arb_valid;
    logic [ID_W-1:0]  arb_grant;
    logic [WIDTH-1:0] result;

    std_rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req        (req_go),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

    always_comb begin
        result = '0;
        case (op_q)
            OP_ADD:  result = left_q + right_q;
            OP_SUB:  result = left_q - right_q;
            OP_MUL:  result = left_q * right_q;
`ifdef SHARED_FU_DIV_EN
            OP_DIV:  result = (right_q == '0) ? '1 : left_q / right_q;
`else
            OP_DIV:  result = '0;
`endif
            default: result = '0;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= OP_ADD;
            left_q     <= '0;
            right_q    <= '0;
            cnt        <= '0;
            last_grant <= ID_W'(NREQ - 1);
            grant_id   <= '0;
            out        <= '0;
            req_done   <= '0;
            busy       <= 1'b0;
        end else begin
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        op_q       <= fu_op_t'(req_op[arb_grant*OP_W +: OP_W]);
                        left_q     <= req_left[arb_grant*WIDTH +: WIDTH];
                        right_q    <= req_right[arb_grant*WIDTH +: WIDTH];
                        grant_id   <= arb_grant;
                        last_grant <= arb_grant;
                        cnt        <= CNT_INIT;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        out                <= result;
                        req_done[grant_id] <= 1'b1;
                        state              <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_std_shared_fu_sched.sv
// Directed bench: three scheduler instances (32b/L1, 8b/L1, 32b/L4) sharing clock and reset.
module tb_std_shared_fu_sched;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: WIDTH=32, LATENCY=1
    logic [3:0]   go_a;
    logic [7:0]   op_a;
    logic [127:0] left_a, right_a;
    logic [3:0]   done_a;
    logic [31:0]  out_a;
    logic         busy_a;
    logic [1:0]   gid_a;

    // Instance B: WIDTH=8, LATENCY=1
    logic [3:0]   go_b;
    logic [7:0]   op_b;
    logic [31:0]  left_b, right_b;
    logic [3:0]   done_b;
    logic [7:0]   out_b;
    logic         busy_b;
    logic [1:0]   gid_b;

    // Instance C: WIDTH=32, LATENCY=4
    logic [3:0]   go_c;
    logic [7:0]   op_c;
    logic [127:0] left_c, right_c;
    logic [3:0]   done_c;
    logic [31:0]  out_c;
    logic         busy_c;
    logic [1:0]   gid_c;

    std_shared_fu_sched #(.WIDTH(32), .NREQ(4), .LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .req_go(go_a), .req_op(op_a),
        .req_left(left_a), .req_right(right_a), .req_done(done_a),
        .out(out_a), .busy(busy_a), .grant_id(gid_a)
    );

    std_shared_fu_sched #(.WIDTH(8), .NREQ(4), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .req_go(go_b), .req_op(op_b),
        .req_left(left_b), .req_right(right_b), .req_done(done_b),
        .out(out_b), .busy(busy_b), .grant_id(gid_b)
    );

    std_shared_fu_sched #(.WIDTH(32), .NREQ(4), .LATENCY(4)) dut_c (
        .clk(clk), .reset(reset), .req_go(go_c), .req_op(op_c),
        .req_left(left_c), .req_right(right_c), .req_done(done_c),
        .out(out_c), .busy(busy_c), .grant_id(gid_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request on A; drive in an IDLE cycle, expect done two cycles later.
    task automatic run_a(input int id, input logic [1:0] op, input logic [31:0] l, input logic [31:0] r,
                         input logic [31:0] exp, input string tag);
        int c;
        c = 0;
        @(negedge clk);
        go_a[id] = 1'b1;
        op_a[id*2 +: 2] = op;
        left_a[id*32 +: 32] = l;
        right_a[id*32 +: 32] = r;
        do begin
            @(negedge clk);
            c++;
        end while (done_a == 4'b0 && c < 20);
        go_a[id] = 1'b0;
        check({tag, "_cyc"}, 32'(c), 32'd2);
        check({tag, "_done"}, 32'(done_a), 32'(4'b1 << id));
        check({tag, "_out"}, out_a, exp);
    endtask

    task automatic run_b(input int id, input logic [1:0] op, input logic [7:0] l, input logic [7:0] r,
                         input logic [7:0] exp, input string tag);
        int c;
        c = 0;
        @(negedge clk);
        go_b[id] = 1'b1;
        op_b[id*2 +: 2] = op;
        left_b[id*8 +: 8] = l;
        right_b[id*8 +: 8] = r;
        do begin
            @(negedge clk);
            c++;
        end while (done_b == 4'b0 && c < 20);
        go_b[id] = 1'b0;
        check({tag, "_cyc"}, 32'(c), 32'd2);
        check({tag, "_out"}, 32'(out_b), 32'(exp));
    endtask

    task automatic run_c(input int id, input logic [1:0] op, input logic [31:0] l, input logic [31:0] r,
                         input logic [31:0] exp, input string tag);
        int c;
        c = 0;
        @(negedge clk);
        go_c[id] = 1'b1;
        op_c[id*2 +: 2] = op;
        left_c[id*32 +: 32] = l;
        right_c[id*32 +: 32] = r;
        do begin
            @(negedge clk);
            c++;
        end while (done_c == 4'b0 && c < 30);
        go_c[id] = 1'b0;
        check({tag, "_cyc"}, 32'(c), 32'd5);
        check({tag, "_done"}, 32'(done_c), 32'(4'b1 << id));
        check({tag, "_out"}, out_c, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    logic [1:0] rearm;
    logic [3:0] seen;
    int n, k;
    logic [31:0] div_exp0, div_exp1;

    initial begin
        go_a = '0; op_a = '0; left_a = '0; right_a = '0;
        go_b = '0; op_b = '0; left_b = '0; right_b = '0;
        go_c = '0; op_c = '0; left_c = '0; right_c = '0;
        rearm = '0; seen = '0; n = 0; k = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out", out_a, 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_gid", 32'(gid_a), 32'd0);

        // Single requester: go[2] add 7+5
        reset = 1'b0;
        go_a[2] = 1'b1;
        op_a[5:4] = 2'b00;
        left_a[95:64] = 32'd7;
        right_a[95:64] = 32'd5;
        @(negedge clk);
        check("t1_busy_c1", 32'(busy_a), 32'd1);
        check("t1_gid_c1", 32'(gid_a), 32'd2);
        check("t1_done_c1", 32'(done_a), 32'd0);
        left_a[95:64] = 32'd99;
        @(negedge clk);
        check("t1_done_c2", 32'(done_a), 32'b0100);
        check("t1_out_c2", out_a, 32'd12);
        check("t1_gid_c2", 32'(gid_a), 32'd2);
        go_a = '0;
        @(negedge clk);
        check("t1_done_c3", 32'(done_a), 32'd0);
        check("t1_busy_c3", 32'(busy_a), 32'd0);
        check("t1_out_hold", out_a, 32'd12);

        // All four requesters at once, mul i*3
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t2_rst_out", out_a, 32'd0);
        go_a = 4'b1111;
        op_a = 8'b10101010;
        for (int i = 0; i < 4; i++) begin
            left_a[i*32 +: 32] = 32'(i);
            right_a[i*32 +: 32] = 32'd3;
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c >= 2 && (c - 2) % 3 == 0 && (c - 2) / 3 < 4) begin
                check($sformatf("t2_done_c%0d", c), 32'(done_a), 32'(4'b1 << ((c - 2) / 3)));
                check($sformatf("t2_out_c%0d", c), out_a, 32'(3 * ((c - 2) / 3)));
            end else begin
                check($sformatf("t2_done_c%0d", c), 32'(done_a), 32'd0);
            end
            go_a = go_a & ~done_a;
        end

        // Fairness: requesters 0 (sub 10-3) and 1 (add ffffffff+2) re-assert one cycle after done
        go_a = 4'b0011;
        op_a = 8'b00000001;
        left_a[31:0] = 32'd10;           right_a[31:0] = 32'd3;
        left_a[63:32] = 32'hFFFF_FFFF;   right_a[63:32] = 32'd2;
        n = 0; k = 0; rearm = '0;
        while (n < 6 && k < 40) begin
            @(negedge clk);
            k++;
            go_a[1:0] = go_a[1:0] | rearm;
            rearm = '0;
            if (done_a != 4'b0) begin
                check($sformatf("fair_who%0d", n), 32'(done_a), 32'(4'b1 << (n % 2)));
                check($sformatf("fair_out%0d", n), out_a, (n % 2 == 0) ? 32'd7 : 32'd1);
                go_a[1:0] = go_a[1:0] & ~done_a[1:0];
                rearm = done_a[1:0];
                n++;
            end
        end
        check("fair_count", 32'(n), 32'd6);
        go_a = '0;

        // Op 11: divider when enabled, zero result otherwise
`ifdef SHARED_FU_DIV_EN
        div_exp0 = 32'd14;
        div_exp1 = 32'hFFFF_FFFF;
`else
        div_exp0 = 32'd0;
        div_exp1 = 32'd0;
`endif
        run_a(1, 2'b11, 32'd100, 32'd7, div_exp0, "div_100_7");
        run_a(3, 2'b11, 32'd9, 32'd0, div_exp1, "div_9_0");
        run_a(0, 2'b00, 32'd40, 32'd2, 32'd42, "add_after_div");

        // WIDTH=8 wrap-around
        run_b(0, 2'b01, 8'd3, 8'd5, 8'd254, "w8_sub");
        run_b(1, 2'b00, 8'd255, 8'd1, 8'd0, "w8_add_wrap");
        run_b(2, 2'b00, 8'd200, 8'd100, 8'd44, "w8_add");
        run_b(3, 2'b10, 8'd16, 8'd16, 8'd0, "w8_mul");

        // LATENCY=4: normal op, then reset in the second EXEC cycle
        run_c(1, 2'b00, 32'd1, 32'd2, 32'd3, "l4_add");
        @(negedge clk);
        go_c[3] = 1'b1;
        op_c[7:6] = 2'b00;
        left_c[127:96] = 32'd5;
        right_c[127:96] = 32'd6;
        @(negedge clk);
        check("l4_busy_exec1", 32'(busy_c), 32'd1);
        check("l4_gid_exec1", 32'(gid_c), 32'd3);
        @(negedge clk);
        reset = 1'b1;
        go_c = '0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy_c), 32'd0);
        check("abort_out", out_c, 32'd0);
        check("abort_done", 32'(done_c), 32'd0);
        check("abort_gid", 32'(gid_c), 32'd0);
        seen = '0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | done_c;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // go[3] and go[0] together after reset: requester 0 first
        go_c = 4'b1001;
        op_c = 8'b00000000;
        left_c[31:0] = 32'd10;   right_c[31:0] = 32'd20;
        @(negedge clk);
        check("pair_gid", 32'(gid_c), 32'd0);
        check("pair_busy", 32'(busy_c), 32'd1);
        n = 0; k = 0;
        while (n < 2 && k < 30) begin
            @(negedge clk);
            k++;
            if (done_c != 4'b0) begin
                check($sformatf("pair_who%0d", n), 32'(done_c), (n == 0) ? 32'b0001 : 32'b1000);
                check($sformatf("pair_out%0d", n), out_c, (n == 0) ? 32'd30 : 32'd11);
                go_c = go_c & ~done_c;
                n++;
            end
        end
        check("pair_count", 32'(n), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/std_shared_fu_sched.md
# std_shared_fu_sched

Round-robin scheduler that shares one arithmetic functional unit (add/sub/mul, optional div) among NREQ requesters using the go/done convention. It sits between several control groups that each want an arithmetic result and a single physical adder/multiplier instance. It arbitrates, latches operands, models the unit's LATENCY, and returns a registered result with a one-cycle done pulse to the granted requester.

## Interface
- WIDTH, 32, operand/result width
- NREQ, 4, number of requesters (≥2)
- LATENCY, 1, cycles the unit is occupied per operation (≥1)

- clk  input  1  clock
- reset  input  1  synchronous, active-high
- req_go  input  NREQ  per-requester request; held high until its done
- req_op  input  2*NREQ  op per requester: 00 add, 01 sub, 10 mul, 11 div
- req_left  input  WIDTH*NREQ  left operands, packed, requester i at [i*WIDTH +: WIDTH]
- req_right  input  WIDTH*NREQ  right operands, same packing
- req_done  output  NREQ  one-hot, one-cycle completion pulse
- out  output  WIDTH  shared result register
- busy  output  1  high in EXEC and DONE
- grant_id  output  $clog2(NREQ)  index of current/last granted requester

## Operation
- FSM: IDLE → EXEC → DONE → IDLE.
- IDLE: if any req_go, pick winner round-robin starting at last_grant+1 mod NREQ. At the clock edge, latch op/left/right/id, update grant_id and last_grant, load cycle counter with LATENCY-1, and go to EXEC. With no req_go, stay in IDLE.
- EXEC: counter decrements each cycle. On the cycle it is 0, compute the result from the latched operands, write it into out, and go to DONE.
- DONE: req_done[grant_id]=1 for exactly this cycle, then IDLE. req_go is ignored in DONE.
- Requesters must drop go the cycle after done. If go is still high in the next IDLE cycle, it is a new request.
- Operand or go changes after the grant are ignored. The operation completes and done pulses even if go was dropped.
- Arithmetic is unsigned and truncated to WIDTH: add/sub wrap modulo 2^WIDTH; mul keeps the low WIDTH bits.
- out holds its value until the next completion.
- Reset values: state IDLE, out 0, req_done 0, busy 0, grant_id 0, last_grant NREQ-1 (requester 0 first).
- Reset in any state aborts the operation with no done pulse and returns all outputs to their reset values.

## Timing
- go first seen in IDLE at cycle t → done at cycle t+LATENCY+1, with out valid in that same cycle.
- Back-to-back service period: LATENCY+2 cycles per operation.
- Grant decision is combinational in IDLE. All outputs are registered.
- Simultaneous requests are resolved in a single cycle. Losers keep go high and are served in rotation.

## Configuration
- SHARED_FU_DIV_EN defined: op 11 is unsigned left/right. Divide by zero yields all-ones (2^WIDTH-1).
- SHARED_FU_DIV_EN undefined: no divider is synthesized. Op 11 produces out=0 and still completes with a done pulse after the normal latency.

## Structure
- Package std_shared_fu_pkg contains:
  - fu_op_t enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
  - sched_state_t enum (IDLE, EXEC, DONE)
  - op-width constant 2
- Sub-module std_rr_arbiter (parameter NREQ):
  - inputs: request vector, last_grant
  - outputs: valid, grant index
  - purely combinational rotate/priority-encode
- Top module holds the FSM, operand/result registers, latency counter and ALU.

## Test plan
- Single requester, WIDTH=32, LATENCY=1: go[2] with add 7+5 at cycle 0 → req_done=0100 at cycle 2, out=12, grant_id=2.
- All four go at cycle 0 after reset, mul i*3 for requester i, LATENCY=1:
  - done order 0,1,2,3 at cycles 2,5,8,11
  - out = 0,3,6,9
- Fairness: requesters 0 and 1 each re-assert go one cycle after every done → grants alternate 0,1,0,1; neither is granted twice in a row.
- Wrap, WIDTH=8: sub 3-5 → 254; mul 16*16 → 0; add 255+1 → 0.
- LATENCY=4, reset asserted in the second EXEC cycle:
  - no done pulse, out=0, busy=0
  - a following go[3] plus go[0] pair grants 0 first
- Macro defined: div 100/7 → 14; 9/0 → 0xFFFFFFFF. Macro undefined: op 11 → out=0, done at t+LATENCY+1.
